// File: rtl/ifetch_queue.sv
// Instruction prefetch queue between imem and the IF/ID register.
// Define IFQ_BYPASS_EN to forward a response straight to an empty head.
module ifetch_queue #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               deq_ready,
  output logic               deq_valid,
  output logic [INSTR_W-1:0] deq_instr,
  output logic [ADDR_W-1:0]  deq_pc,
  output logic [ADDR_W-1:0]  deq_pcplus4
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {
    FREE,
    PEND,
    FILL
  } slot_e;

  localparam cnt_t FULL = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  slot_e               st_q    [DEPTH];
  logic [ADDR_W-1:0]   pc_q    [DEPTH];
  logic [INSTR_W-1:0]  instr_q [DEPTH];

  ptr_t                alloc_ptr;
  ptr_t                fill_ptr;
  ptr_t                head_ptr;
  cnt_t                used;
  cnt_t                pend;
  cnt_t                drop_cnt;
  logic [ADDR_W-1:0]   fetch_pc;

  logic                req_fire;
  logic                rsp_drop;
  logic                rsp_fill;
  logic                head_filled;
  logic                byp;
  logic                deq_fire;
  logic                byp_take;
  logic                unused_lsb;

  assign unused_lsb = ^redirect_pc_i[1:0];

  assign imem_req_valid = !reset && !redirect_i
                       && (used < FULL);
  assign imem_req_addr  = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding fall through both terms.
  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill = imem_rsp_valid && (drop_cnt == '0)
                 && (pend != '0);

  assign head_filled = (st_q[head_ptr] == FILL);

`ifdef IFQ_BYPASS_EN
  assign byp = rsp_fill && (fill_ptr == head_ptr)
            && (st_q[head_ptr] == PEND);
  assign deq_instr = head_filled ? instr_q[head_ptr]
                                 : imem_rsp_data;
`else
  assign byp = 1'b0;
  assign deq_instr = instr_q[head_ptr];
`endif

  assign deq_valid   = !reset && (head_filled || byp);
  assign deq_pc      = pc_q[head_ptr];
  assign deq_pcplus4 = pc_q[head_ptr] + STEP;
  assign deq_fire    = deq_valid && deq_ready && !redirect_i;
  assign byp_take    = byp && deq_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      used      <= '0;
      pend      <= '0;
      drop_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) st_q[i] <= FREE;
    end else if (redirect_i) begin
      fetch_pc  <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      used      <= '0;
      pend      <= '0;
      // Every still-pending fetch becomes a stale response to swallow.
      drop_cnt  <= drop_cnt - cnt_t'(rsp_drop)
                 + pend - cnt_t'(rsp_fill);
      for (int i = 0; i < DEPTH; i++) st_q[i] <= FREE;
    end else begin
      if (req_fire) begin
        st_q[alloc_ptr] <= PEND;
        alloc_ptr       <= alloc_ptr + 1'b1;
        fetch_pc        <= fetch_pc + STEP;
      end
      if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
      if (rsp_fill) begin
        fill_ptr <= fill_ptr + 1'b1;
        if (!byp_take) st_q[fill_ptr] <= FILL;
      end
      if (deq_fire) begin
        st_q[head_ptr] <= FREE;
        head_ptr       <= head_ptr + 1'b1;
      end
      used <= used + cnt_t'(req_fire) - cnt_t'(deq_fire);
      pend <= pend + cnt_t'(req_fire) - cnt_t'(rsp_fill);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pc_q[alloc_ptr] <= fetch_pc;
    if (rsp_fill) instr_q[fill_ptr] <= imem_rsp_data;
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Random bench for ifetch_queue against an epoch-tagged imem and queue model.
// Stale fetches are identified by redirect epoch, not by a drop counter.
module tb_ifetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc;
  logic [31:0] deq_pcplus4;

  always #5 clk = ~clk;

  ifetch_queue #(
    .ADDR_W(32),
    .INSTR_W(32),
    .DEPTH(DEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .deq_ready(deq_ready),
    .deq_valid(deq_valid),
    .deq_instr(deq_instr),
    .deq_pc(deq_pc),
    .deq_pcplus4(deq_pcplus4)
  );

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } txn_t;

  txn_t        imq[$];
  logic [31:0] live[$];
  int          filled;
  int          epoch;
  int          cyc;
  int          last_due;
  logic [31:0] exp_fetch;

  int          lat_lo, lat_hi, p_redir;
  int          rr_mode, dr_mode;
  int          force_at;
  logic [31:0] force_tgt;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_deq = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s @cyc %0d: got %h expected %h",
                 tag, cyc, got, exp);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_i     = 1'b0;
    redirect_pc_i  = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    deq_ready      = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("rst_deq_valid", {31'b0, deq_valid}, 32'd0);
    end
    reset = 1'b0;
    imq.delete();
    live.delete();
    filled    = 0;
    epoch     = 0;
    cyc       = 0;
    last_due  = 0;
    exp_fetch = 32'h0;
    force_at  = -1;
  endtask

  task automatic run(input int n);
    logic        rlive;
    logic        exp_rv;
    logic        exp_dv;
    logic [31:0] tgt;
    int          lat;
    int          due;
    for (int k = 0; k < n; k++) begin
      rlive = 1'b0;
      if (imq.size() > 0 && imq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem(imq[0].addr);
        rlive          = (imq[0].ep == epoch);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      if (cyc == force_at) tgt = force_tgt;
      else if ($urandom_range(3) == 0)
        tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else tgt = $urandom;
      redirect_i = (cyc == force_at)
                || ($urandom_range(99) < p_redir);
      redirect_pc_i = tgt;
      case (rr_mode)
        0: imem_req_ready = 1'b1;
        1: imem_req_ready = (cyc % 2 == 0);
        default: imem_req_ready = $urandom_range(1) == 1;
      endcase
      case (dr_mode)
        0: deq_ready = 1'b1;
        1: deq_ready = 1'b0;
        default: deq_ready = $urandom_range(2) != 0;
      endcase
      #1;

      exp_rv = !redirect_i && (live.size() < DEPTH);
`ifdef IFQ_BYPASS_EN
      exp_dv = (filled > 0) || (imem_rsp_valid && rlive);
`else
      exp_dv = (filled > 0);
`endif
      check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
      if (exp_rv) check("req_addr", imem_req_addr, exp_fetch);
      check("deq_valid", {31'b0, deq_valid}, {31'b0, exp_dv});
      if (exp_dv && live.size() > 0) begin
        check("deq_pc", deq_pc, live[0]);
        check("deq_pcplus4", deq_pcplus4, live[0] + 32'd4);
        check("deq_instr", deq_instr, mem(live[0]));
      end

      if (imem_rsp_valid) begin
        void'(imq.pop_front());
        if (rlive) filled++;
      end
      if (exp_dv && deq_ready && !redirect_i && live.size() > 0) begin
        void'(live.pop_front());
        filled--;
        n_deq++;
      end
      if (imem_req_valid && imem_req_ready) begin
        lat = $urandom_range(lat_hi, lat_lo);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        imq.push_back('{imem_req_addr, epoch, due});
      end
      if (redirect_i) begin
        live.delete();
        filled    = 0;
        epoch++;
        exp_fetch = {tgt[31:2], 2'b00};
      end else if (exp_rv && imem_req_ready) begin
        live.push_back(exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end

      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    reset = 1'b1;
    // Streaming at full rate with a 1-cycle imem.
    do_reset();
    lat_lo = 1; lat_hi = 1; p_redir = 0;
    rr_mode = 0; dr_mode = 0;
    run(24);

    // Consumer stalled: queue fills to DEPTH, then drains.
    do_reset();
    lat_lo = 1; lat_hi = 1; p_redir = 0;
    rr_mode = 0; dr_mode = 1;
    run(10);
    dr_mode = 0;
    run(12);

    // Redirect with three fetches in flight on a 3-cycle imem.
    do_reset();
    lat_lo = 3; lat_hi = 3; p_redir = 0;
    rr_mode = 0; dr_mode = 0;
    force_at = 3; force_tgt = 32'h0000_0103;
    run(20);

    // Random latency, toggling then random request ready, redirects.
    do_reset();
    lat_lo = 1; lat_hi = 4; p_redir = 5;
    rr_mode = 1; dr_mode = 2;
    run(1500);
    rr_mode = 2;
    run(1500);

    check("deq_progress", {31'b0, n_deq > 500}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
